serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_serial_frame_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampled serial frame receiver.
// Synchronizes the serial line, finds the start bit, samples DATA_W bits
// LSB-first at mid-bit and checks the stop bit. Good bytes go out as a
// one-cycle write to the downstream FIFO; framing and overrun errors pulse.
// Optional build macro SERIAL_FRAME_RX_PARITY_EN adds an even-parity bit
// between data and stop, and a parity_err pulse output.
//
// Handshake: wr is a one-cycle strobe with dout valid while wr=1. There is
// no back-pressure on the line; when fifo_full=1 at the stop sample the byte
// is dropped and overrun pulses instead of wr.
module serial_frame_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              fifo_full,
   output logic              wr,
   output logic [DATA_W-1:0] dout,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
`ifdef SERIAL_FRAME_RX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic              sync1_q, s_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              armed_q, armed_d;
   logic              par_bad;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic              par_q, par_d;
   logic              parity_err_c;
   assign par_bad    = ^{shift_q, par_q};
   assign parity_err = parity_err_c;
`else
   assign par_bad = 1'b0;
`endif

   // Two-flop synchronizer; the idle-high line resets to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         s_q     <= 1'b1;
      end else begin
         sync1_q <= sin;
         s_q     <= sync1_q;
      end
   end

   // State, counters, shift register and held output byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         armed_q <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         armed_q <= armed_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic and the one-cycle result pulses at the stop sample.
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      dout_d    = dout_q;
      armed_d   = armed_q | s_q;
      wr        = 1'b0;
      frame_err = 1'b0;
      overrun   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_d        = par_q;
      parity_err_c = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // A falling edge only counts once the line was seen high again.
            if (!s_q && armed_q) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               if (!s_q) begin
                  state_d = DATA;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               shift_d = {s_q, shift_q[DATA_W-1:1]};
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef SERIAL_FRAME_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_FULL) begin
               par_d   = s_q;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               state_d = IDLE;
               if (!s_q) begin
                  frame_err = 1'b1;
                  armed_d   = 1'b0;
               end else if (par_bad) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  parity_err_c = 1'b1;
`endif
               end else if (fifo_full) begin
                  overrun = 1'b1;
               end else begin
                  wr     = 1'b1;
                  dout_d = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Baud counter restarts on every state entry and rests in IDLE.
      if (state_d != state_q || state_q == IDLE) cnt_d = '0;
      else                                        cnt_d = cnt_q + 1'b1;
   end

   // The new byte is presented in the same cycle as its write strobe.
   assign dout = wr ? shift_q : dout_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx (default build, no parity).
module tb_serial_frame_rx;
  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB;  // 154 cycles fall-to-wr
  localparam logic [2:0] K_WR = 3'b100;
  localparam logic [2:0] K_FE = 3'b010;
  localparam logic [2:0] K_OV = 3'b001;

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          fifo_full;
  logic          wr;
  logic [DW-1:0] dout;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // expected event: {cycle[31:0], kind[2:0] = {wr,frame_err,overrun}, data[7:0]}
  logic [42:0]   exp_q[$];
  logic [42:0]   mon_e;
  logic [DW-1:0] last_wr;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       full;
    logic [2:0] kind;
  } vec_t;
  vec_t vecs[6];

  serial_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .fifo_full (fifo_full),
    .wr        (wr),
    .dout      (dout),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // scoreboard: every result pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst) begin
      last_wr = '0;
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][42:11]) < cyc) begin
        mon_e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: got no pulse, expected kind %b data %0h at cycle %0d",
                 mon_e[10:8], mon_e[7:0], mon_e[42:11]);
      end
      if (wr || frame_err || overrun) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_pulse: got kind %b, expected none (cycle %0d)",
                   {wr, frame_err, overrun}, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), mon_e[42:11]);
          check("event_kind", 32'({wr, frame_err, overrun}), 32'(mon_e[10:8]));
          if (mon_e[10]) check("wr_dout", 32'(dout), 32'(mon_e[7:0]));
          else           check("held_dout", 32'(dout), 32'(last_wr));
          if (mon_e[10]) last_wr = mon_e[7:0];
        end
      end
    end
  end

  // driver tasks: each returns 1 time unit after a rising edge
  task automatic hold_bit(input logic v);
    sin = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic full,
                            input logic [2:0] kind);
    fifo_full = full;
    exp_q.push_back({32'(cyc + LAT), kind, d});
    hold_bit(1'b0);
    for (int i = 0; i < DW; i++) hold_bit(d[i]);
    hold_bit(stop_bit);
  endtask

  // reference rule for a complete frame sent on an armed line
  function automatic logic [2:0] model_kind(input logic stop_bit, input logic full);
    if (!stop_bit) return K_FE;
    if (full)      return K_OV;
    return K_WR;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_wr"},   32'(wr),        32'd0);
    check({tag, "_fe"},   32'(frame_err), 32'd0);
    check({tag, "_ov"},   32'(overrun),   32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
    check({tag, "_dout"}, 32'(dout),      32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, expected end of test (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, K_WR};
    vecs[1] = '{8'h81, 1'b1, 1'b1, K_OV};
    vecs[2] = '{8'h7E, 1'b1, 1'b0, K_WR};
    vecs[3] = '{8'h01, 1'b0, 1'b0, K_FE};
    vecs[4] = '{8'h80, 1'b1, 1'b0, K_WR};
    vecs[5] = '{8'hC3, 1'b0, 1'b1, K_FE};

    // reset
    rst = 1'b1;
    sin = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    // long idle line
    idle(500);
    check("idle_busy", 32'(busy), 32'd0);

    // table-driven frames with a short idle gap
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].full, vecs[i].kind);
      idle(20);
      check("vec_busy", 32'(busy), 32'd0);
    end
    fifo_full = 1'b0;

    // glitch: 4 low cycles, rejected at the mid-start sample
    begin
      sin = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("glitch_busy_hi", 32'(busy), 32'd1);
      idle(12);
      check("glitch_busy_lo", 32'(busy), 32'd0);
      idle(20);
    end

    // framing error followed by a break: no retrigger until line goes high
    send_frame(8'h3C, 1'b0, 1'b0, K_FE);
    sin = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("break_busy", 32'(busy), 32'd0);
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0, K_WR);
    idle(20);

    // back-to-back frames, then reset in the middle of a fourth
    send_frame(8'h00, 1'b1, 1'b0, K_WR);
    send_frame(8'hFF, 1'b1, 1'b0, K_WR);
    send_frame(8'h55, 1'b1, 1'b0, K_WR);
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    rst = 1'b1;
    sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("mid_reset");
    rst = 1'b0;
    idle(300);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);

    // randomized frames against the reference rule
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic       stop_bit;
      logic       full;
      int         gap;
      d        = 8'($urandom_range(0, 255));
      full     = ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 4) != 0);
      gap      = $urandom_range(stop_bit ? 0 : 1, 6);
      send_frame(d, stop_bit, full, model_kind(stop_bit, full));
      if (gap > 0) idle(gap);
    end
    fifo_full = 1'b0;
    idle(200);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
